// File: rtl/pet_needs_timer.sv
// pet_needs_timer: ages hunger/fun/energy on tick_in edges and runs the AWAKE/SLEEPING/DEAD life FSM.
// Optional NEEDS_FAST_DECAY_EN forces every aging period to 1 tick.
module pet_needs_timer #(
  parameter int MAX_LEVEL     = 5,
  parameter int ALERT_LEVEL   = 1,
  parameter int HUNGER_PERIOD = 10,
  parameter int FUN_PERIOD    = 15,
  parameter int ENERGY_PERIOD = 20,
  parameter int SLEEP_PERIOD  = 4,
  parameter int FEED_STEP     = 2,
  parameter int PLAY_STEP     = 2,
  parameter int STARVE_TICKS  = 8
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       enable,
  input  logic       feed,
  input  logic       play,
  input  logic       sleep,
  output logic [2:0] hunger_lvl,
  output logic [2:0] fun_lvl,
  output logic [2:0] energy_lvl,
  output logic [1:0] pet_state,
  output logic       alert
);
  typedef enum logic [1:0] {AWAKE = 2'b00, SLEEPING = 2'b01, DEAD = 2'b10} state_t;
`ifdef NEEDS_FAST_DECAY_EN
  localparam int HP = 1;
  localparam int FP = 1;
  localparam int EP = 1;
  localparam int SP = 1;
`else
  localparam int HP = HUNGER_PERIOD;
  localparam int FP = FUN_PERIOD;
  localparam int EP = ENERGY_PERIOD;
  localparam int SP = SLEEP_PERIOD;
`endif
  localparam logic [7:0] HR = 8'(HP - 1);
  localparam logic [7:0] FR = 8'(FP - 1);
  localparam logic [7:0] ER = 8'(EP - 1);
  localparam logic [7:0] SR = 8'(SP - 1);
  localparam logic [2:0] MAXL = 3'(MAX_LEVEL);
  localparam logic [2:0] ALRT = 3'(ALERT_LEVEL);
  state_t state, state_n;
  logic s1, s2, prev;
  logic [7:0] hcnt, fcnt, ecnt, scnt, hcnt_n, fcnt_n, ecnt_n, scnt_n;
  logic [2:0] h_n, f_n, e_n;
  logic run, awake, asleep, t, do_feed, do_play, do_sleep, go_sleep, wake;
  logic h_dec, f_dec, e_dec, e_inc;
  // Widened to 5 bits so a negative result is visible in the top bit before clamping.
  function automatic logic [2:0] sat(input logic [2:0] lvl, input logic [1:0] dec, input logic [3:0] step);
    logic [4:0] v;
    v = 5'(lvl) + 5'(step) - 5'(dec);
    return v[4] ? 3'd0 : (v > 5'(MAXL) ? MAXL : v[2:0]);
  endfunction
  assign run      = enable & (state != DEAD);
  assign awake    = state == AWAKE;
  assign asleep   = state == SLEEPING;
  assign t        = run & s2 & ~prev;
  assign do_sleep = run & sleep;
  assign do_feed  = run & awake & feed & ~sleep;
  assign do_play  = run & awake & play & ~sleep & (energy_lvl != 3'd0);
  assign go_sleep = awake & do_sleep;
  assign wake     = asleep & (do_sleep | energy_lvl == MAXL);
  assign h_dec    = t & awake & hcnt == 8'd0;
  assign f_dec    = t & awake & fcnt == 8'd0;
  assign e_dec    = t & awake & ecnt == 8'd0;
  assign e_inc    = t & asleep & ecnt == 8'd0;
  assign pet_state = state;
  always_comb begin
    hcnt_n = do_feed ? HR : (t & awake) ? (h_dec ? HR : hcnt - 8'd1) : hcnt;
    fcnt_n = do_play ? FR : (t & awake) ? (f_dec ? FR : fcnt - 8'd1) : fcnt;
    ecnt_n = go_sleep ? SR : wake ? ER : t ? (ecnt == 8'd0 ? (asleep ? SR : ER) : ecnt - 8'd1) : ecnt;
    scnt_n = (state == DEAD) ? scnt : (hunger_lvl != 3'd0) ? 8'd0 : t ? scnt + 8'd1 : scnt;
    h_n = sat(hunger_lvl, {1'b0, h_dec}, do_feed ? 4'(FEED_STEP) : 4'd0);
    f_n = sat(fun_lvl, {1'b0, f_dec}, do_play ? 4'(PLAY_STEP) : 4'd0);
    e_n = sat(energy_lvl, 2'(e_dec) + 2'(do_play), {3'd0, e_inc});
    state_n = (state == DEAD || scnt >= 8'(STARVE_TICKS)) ? DEAD : go_sleep ? SLEEPING : wake ? AWAKE : state;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      hunger_lvl <= MAXL;
      fun_lvl <= MAXL;
      energy_lvl <= MAXL;
      hcnt <= HR;
      fcnt <= FR;
      ecnt <= ER;
      scnt <= 8'd0;
      state <= AWAKE;
      alert <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      prev <= s2;
      hunger_lvl <= h_n;
      fun_lvl <= f_n;
      energy_lvl <= e_n;
      hcnt <= hcnt_n;
      fcnt <= fcnt_n;
      ecnt <= ecnt_n;
      scnt <= scnt_n;
      state <= state_n;
      alert <= (state_n != DEAD) && (hunger_lvl <= ALRT || fun_lvl <= ALRT || energy_lvl <= ALRT);
    end
  end
endmodule
